id_ex_pipe: RTL



---
 rtl/id_ex_pipe.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register with valid/ready handshake, NOP bubbles and a bubble counter.
// Define ID_EX_SKID_EN for a two-entry skid buffer with a registered id_ready.
module id_ex_pipe #(
    parameter int DATA_W   = 32,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [ADDR_W-1:0]   id_wd,
    input  logic                id_wreg,
    input  logic [DATA_W-1:0]   id_link_addr,
    input  logic                id_in_dslot,
    input  logic                next_in_dslot_i,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_reg1,
    output logic [DATA_W-1:0]   ex_reg2,
    output logic [ADDR_W-1:0]   ex_wd,
    output logic                ex_wreg,
    output logic [DATA_W-1:0]   ex_link_addr,
    output logic                ex_in_dslot,
    output logic                in_dslot_o,
    output logic [CNT_W-1:0]    bubble_cnt
);

    typedef struct packed {
        logic [ALUOP_W-1:0]  aluop;
        logic [ALUSEL_W-1:0] alusel;
        logic [DATA_W-1:0]   reg1;
        logic [DATA_W-1:0]   reg2;
        logic [ADDR_W-1:0]   wd;
        logic                wreg;
        logic [DATA_W-1:0]   link_addr;
        logic                in_dslot;
    } pl_t;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] FULL  = 2'd1;
`ifdef ID_EX_SKID_EN
    localparam logic [1:0] SKID  = 2'd2;
`endif

    logic [1:0]       state_q, state_d;
    pl_t              main_q, main_d;
    pl_t              id_pl;
    logic             dslot_q, dslot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, consume;
`ifdef ID_EX_SKID_EN
    pl_t              skid_q, skid_d;
`endif

    always_comb begin
        id_pl           = '0;
        id_pl.aluop     = id_aluop;
        id_pl.alusel    = id_alusel;
        id_pl.reg1      = id_reg1;
        id_pl.reg2      = id_reg2;
        id_pl.wd        = id_wd;
        id_pl.wreg      = id_wreg;
        id_pl.link_addr = id_link_addr;
        id_pl.in_dslot  = id_in_dslot;
    end

    assign ex_valid = (state_q != EMPTY);

    // Ready is masked during reset so nothing is accepted into a clearing stage.
`ifdef ID_EX_SKID_EN
    assign id_ready = !rst && (state_q != SKID);
`else
    assign id_ready = !rst && (!ex_valid || ex_ready);
`endif

    assign accept  = id_valid && id_ready;
    assign consume = ex_valid && ex_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef ID_EX_SKID_EN
        skid_d  = skid_q;
`endif
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_d  = id_pl;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (consume && accept) begin
                    main_d = id_pl;
                end else if (consume) begin
                    main_d  = '0;
                    state_d = EMPTY;
`ifdef ID_EX_SKID_EN
                end else if (accept) begin
                    skid_d  = id_pl;
                    state_d = SKID;
`endif
                end
            end
`ifdef ID_EX_SKID_EN
            SKID: begin
                if (consume) begin
                    main_d  = skid_q;
                    skid_d  = '0;
                    state_d = FULL;
                end
            end
`endif
            default: begin
                main_d  = '0;
                state_d = EMPTY;
            end
        endcase
        if (flush) begin
            main_d  = '0;
            state_d = EMPTY;
`ifdef ID_EX_SKID_EN
            skid_d  = '0;
`endif
        end
    end

    always_comb begin
        dslot_d = dslot_q;
        if (flush) begin
            dslot_d = 1'b0;
        end else if (accept) begin
            dslot_d = next_in_dslot_i;
        end
    end

    // Saturating count of bubble cycles; flush leaves it alone.
    always_comb begin
        cnt_d = cnt_q;
        if (!ex_valid && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            dslot_q <= 1'b0;
            cnt_q   <= '0;
`ifdef ID_EX_SKID_EN
            skid_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            dslot_q <= dslot_d;
            cnt_q   <= cnt_d;
`ifdef ID_EX_SKID_EN
            skid_q  <= skid_d;
`endif
        end
    end

    assign ex_aluop     = main_q.aluop;
    assign ex_alusel    = main_q.alusel;
    assign ex_reg1      = main_q.reg1;
    assign ex_reg2      = main_q.reg2;
    assign ex_wd        = main_q.wd;
    assign ex_wreg      = main_q.wreg;
    assign ex_link_addr = main_q.link_addr;
    assign ex_in_dslot  = main_q.in_dslot;
    assign in_dslot_o   = dslot_q;
    assign bubble_cnt   = cnt_q;

endmodule
